// File: rtl/pushbuttons_leds_ctrl.sv
// Two-button mode controller: sync, debounce and press detection per button, a 4-state mode FSM and blinking LED outputs.
// Defining PBLED_LONGPRESS_EN adds a PB0 long-press that forces the mode back to OFF.
module pushbuttons_leds_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_HALF      = 12500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PB0_n,
    input  logic       PB1_n,
    output logic       LED0,
    output logic       LED1,
    output logic [1:0] MODE
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] T_SLOW = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] T_FAST = BW'(BLINK_HALF / 4 - 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    logic [1:0] btn_act;
    logic [1:0] press;

    assign btn_act = ~{PB1_n, PB0_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]    sync_d, sync_q;
            logic [DW-1:0] cnt_d, cnt_q;
            logic          deb_d, deb_q;
            logic          prev_q;
            logic          raw;

            assign raw = sync_q[1];

            // Counter only advances while raw disagrees with the accepted level.
            always_comb begin
                sync_d = {sync_q[0], btn_act[gi]};
                cnt_d  = cnt_q;
                deb_d  = deb_q;
                if (raw == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    deb_d = raw;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync_q <= '0;
                    cnt_q  <= '0;
                    deb_q  <= 1'b0;
                    prev_q <= 1'b0;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                    deb_q  <= deb_d;
                    prev_q <= deb_q;
                end
            end

            assign press[gi] = deb_q & ~prev_q;
        end
    endgenerate

    logic long_evt;

`ifdef PBLED_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic          pb0_level;
    logic [HW-1:0] hold_d, hold_q;

    assign pb0_level = g_btn[0].deb_q;

    always_comb begin
        hold_d = '0;
        if (pb0_level) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
    end

    // Fires only on the step into HOLD_MAX, so a saturated hold cannot retrigger.
    assign long_evt = pb0_level && (hold_q == HOLD_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    localparam int unused_long_cycles = LONG_CYCLES;
    assign long_evt = 1'b0;
`endif

    mode_e         mode_d, mode_q;
    logic [BW-1:0] blink_cnt_d, blink_cnt_q;
    logic [BW-1:0] blink_term;
    logic          phase_d, phase_q;
    logic          led0_d, led0_q;
    logic          led1_d, led1_q;

    always_comb begin
        mode_d      = mode_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        led0_d      = 1'b0;
        led1_d      = 1'b0;
        blink_term  = (mode_q == MODE_FAST) ? T_FAST : T_SLOW;

        if (press[1] || long_evt) begin
            mode_d = MODE_OFF;
        end else if (press[0]) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end

        // A mode change restarts the blink so every blink mode opens on phase 0.
        if ((mode_d != mode_q) || (mode_q == MODE_OFF) || (mode_q == MODE_ON)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == blink_term) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        case (mode_q)
            MODE_OFF: begin
                led0_d = 1'b0;
                led1_d = 1'b0;
            end
            MODE_ON: begin
                led0_d = 1'b1;
                led1_d = 1'b1;
            end
            default: begin
                led0_d = phase_q;
                led1_d = ~phase_q;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q      <= MODE_OFF;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            led0_q      <= 1'b0;
            led1_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led0_q      <= led0_d;
            led1_q      <= led1_d;
        end
    end

    assign MODE = mode_q;
    assign LED0 = led0_q;
    assign LED1 = led1_q;

endmodule

// File: tb/tb_pushbuttons_leds_ctrl.sv
// Self-checking bench for pushbuttons_leds_ctrl using a queue of expected MODE/LED snapshots.
// Build with PBLED_LONGPRESS_EN defined to check the long-press variant.
module tb_pushbuttons_leds_ctrl;

    localparam int DB = 4;
    localparam int BH = 8;
    localparam int LC = 20;

    logic       CLK;
    logic       RST;
    logic       PB0_n;
    logic       PB1_n;
    logic       LED0;
    logic       LED1;
    logic [1:0] MODE;

    pushbuttons_leds_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .BLINK_HALF     (BH),
        .LONG_CYCLES    (LC)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .PB0_n(PB0_n),
        .PB1_n(PB1_n),
        .LED0 (LED0),
        .LED1 (LED1),
        .MODE (MODE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic       led0;
        logic       led1;
        logic       chk_led;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] cur_mode = 2'd0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string nm, input logic [1:0] m, input logic l0, input logic l1,
                        input logic chk);
        exp_t x;
        x.name = nm; x.mode = m; x.led0 = l0; x.led1 = l1; x.chk_led = chk;
        sb.push_back(x);
    endtask

    function automatic logic [1:0] leds_for(input logic [1:0] m);
        // {LED0, LED1} one cycle after entering mode m (blink modes start at phase 0)
        case (m)
            2'd0:    return 2'b00;
            2'd1:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic test_reset();
        PB0_n = 1'b1; PB1_n = 1'b1; RST = 1'b0;
        #2 RST = 1'b1;
        push("reset_async", 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        e = sb.pop_front(); n_checks++;
        if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
            n_errors++;
            $display("FAIL %s: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                     e.name, MODE, LED0, LED1, e.mode, e.led0, e.led1);
        end
        step(); step();
        RST = 1'b0;
        for (int i = 0; i < 50; i++) begin
            push("reset_stable", 2'd0, 1'b0, 1'b0, 1'b1);
            step();
            e = sb.pop_front(); n_checks++;
            if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
                n_errors++;
                $display("FAIL %s[%0d]: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                         e.name, i, MODE, LED0, LED1, e.mode, e.led0, e.led1);
            end
        end
        cur_mode = 2'd0;
        $display("reset: idle for 50 cycles, MODE=%0d", MODE);
    endtask

    // Press the buttons in mask for 10 cycles; checks MODE exactly 6 and 7 cycles in, LEDs at 8.
    task automatic test_press(input logic [1:0] mask, input string nm);
        logic [1:0] exp_mode;
        exp_mode = mask[1] ? 2'd0 : cur_mode + 2'd1;
        PB0_n = ~mask[0]; PB1_n = ~mask[1];
        repeat (5) step();
        for (int k = 6; k <= 8; k++) begin
            if (k == 6) push({nm, "_pre"}, cur_mode, 1'b0, 1'b0, 1'b0);
            else if (k == 7) push({nm, "_mode"}, exp_mode, 1'b0, 1'b0, 1'b0);
            else push({nm, "_led"}, exp_mode, leds_for(exp_mode) >> 1, leds_for(exp_mode) & 2'b01, 1'b1);
            step();
            e = sb.pop_front(); n_checks++;
            if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
                n_errors++;
                $display("FAIL %s: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                         e.name, MODE, LED0, LED1, e.mode, e.led0, e.led1);
            end
        end
        step(); step();
        PB0_n = 1'b1; PB1_n = 1'b1;
        repeat (12) step();
        cur_mode = exp_mode;
        $display("press %s (mask %b): MODE=%0d", nm, mask, MODE);
    endtask

    task automatic test_debounce();
        PB0_n = 1'b0;
        repeat (3) step();
        PB0_n = 1'b1;
        repeat (11) step();
        push("glitch_ignored", 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        e = sb.pop_front(); n_checks++;
        if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
            n_errors++;
            $display("FAIL %s: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                     e.name, MODE, LED0, LED1, e.mode, e.led0, e.led1);
        end
        $display("glitch: 3-cycle PB0 pulse, MODE=%0d", MODE);
        test_press(2'b01, "pb0_first");
    endtask

    // Enter a blink mode with PB0 and follow LED0/LED1 cycle by cycle from the entry edge.
    task automatic test_blink_mode(input int half, input int ncyc, input string nm);
        logic [1:0] exp_mode;
        logic       ph;
        exp_mode = cur_mode + 2'd1;
        PB0_n = 1'b0;
        repeat (6) step();
        push({nm, "_entry"}, exp_mode, 1'b0, 1'b0, 1'b0);
        step();
        e = sb.pop_front(); n_checks++;
        if (MODE !== e.mode) begin
            n_errors++;
            $display("FAIL %s: MODE=%0d expected MODE=%0d", e.name, MODE, e.mode);
        end
        for (int k = 1; k <= ncyc; k++) begin
            if (k == 4) PB0_n = 1'b1;
            ph = ((k - 1) / half) % 2 == 1;
            push(nm, exp_mode, ph, ~ph, 1'b1);
            step();
            e = sb.pop_front(); n_checks++;
            if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
                n_errors++;
                $display("FAIL %s[%0d]: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                         e.name, k, MODE, LED0, LED1, e.mode, e.led0, e.led1);
            end
        end
        cur_mode = exp_mode;
        $display("blink %s: followed %0d cycles, MODE=%0d", nm, ncyc, MODE);
    endtask

    task automatic test_blink();
        test_blink_mode(BH, 3 * BH, "slow");
        test_blink_mode(BH / 4, 12, "fast");
        test_press(2'b01, "wrap_off");
    endtask

    task automatic test_simultaneous();
        test_press(2'b01, "to_on");
        test_press(2'b01, "to_slow");
        test_press(2'b11, "both");
        for (int i = 0; i < 10; i++) begin
            push("both_idle", 2'd0, 1'b0, 1'b0, 1'b1);
            step();
            e = sb.pop_front(); n_checks++;
            if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
                n_errors++;
                $display("FAIL %s[%0d]: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                         e.name, i, MODE, LED0, LED1, e.mode, e.led0, e.led1);
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        test_press(2'b01, "r_on");
        test_press(2'b01, "r_slow");
        test_press(2'b01, "r_fast");
        repeat (5) step();
        PB0_n = 1'b0;
        repeat (3) step();
        #2 RST = 1'b1;
        push("rst_async", 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        e = sb.pop_front(); n_checks++;
        if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
            n_errors++;
            $display("FAIL %s: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                     e.name, MODE, LED0, LED1, e.mode, e.led0, e.led1);
        end
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 6) push("rst_held", 2'd0, 1'b0, 1'b0, 1'b1);
            else if (k == 7) push("rst_press_mode", 2'd1, 1'b0, 1'b0, 1'b1);
            else push("rst_press_led", 2'd1, 1'b1, 1'b1, 1'b1);
            step();
            e = sb.pop_front(); n_checks++;
            if (MODE !== e.mode || (e.chk_led && (LED0 !== e.led0 || LED1 !== e.led1))) begin
                n_errors++;
                $display("FAIL %s[%0d]: MODE=%0d LED0=%b LED1=%b expected MODE=%0d LED0=%b LED1=%b",
                         e.name, k, MODE, LED0, LED1, e.mode, e.led0, e.led1);
            end
        end
        PB0_n = 1'b1;
        repeat (12) step();
        cur_mode = 2'd1;
        $display("reset mid-blink: held PB0 re-pressed after release, MODE=%0d", MODE);
    endtask

    task automatic test_longpress();
        logic [1:0] late_mode;
`ifdef PBLED_LONGPRESS_EN
        late_mode = 2'd0;
`else
        late_mode = 2'd1;
`endif
        test_press(2'b10, "pb1_clear");
        PB0_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 7 || k == 25) begin
                push("long_early", 2'd1, 1'b0, 1'b0, 1'b0);
            end else if (k == 26 || k == 40) begin
                push("long_late", late_mode, 1'b0, 1'b0, 1'b0);
            end else begin
                continue;
            end
            e = sb.pop_front(); n_checks++;
            if (MODE !== e.mode) begin
                n_errors++;
                $display("FAIL %s[%0d]: MODE=%0d expected MODE=%0d", e.name, k, MODE, e.mode);
            end
        end
        PB0_n = 1'b1;
        repeat (12) step();
        push("long_released", late_mode, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if (MODE !== e.mode) begin
            n_errors++;
            $display("FAIL %s: MODE=%0d expected MODE=%0d", e.name, MODE, e.mode);
        end
        $display("long press: 40-cycle PB0 hold, MODE=%0d", MODE);
    endtask

    initial begin
        PB0_n = 1'b1;
        PB1_n = 1'b1;
        RST   = 1'b0;
        test_reset();
        test_debounce();
        test_blink();
        test_simultaneous();
        test_reset_mid_blink();
        test_longpress();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pushbuttons_leds_ctrl.md
Name: pushbuttons_leds_ctrl

Overview:
Mode controller between the two active-low board pushbuttons and the two LEDs. Each button is synchronised, debounced and edge-detected. A 4-state mode FSM is driven from the button presses. LED0/LED1 are sequenced as off, on, slow blink or fast blink. It replaces the direct button-to-LED wiring as the top-level LED owner.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a button change; minimum 1.
BLINK_HALF, 12500000, slow-blink half period in cycles; must be a multiple of 4 and at least 4.
LONG_CYCLES, 50000000, hold time for long press; used only with the optional feature.

Ports:
CLK  in  1  system clock; all state is on the rising edge.
RST  in  1  asynchronous, active-high reset.
PB0_n  in  1  pushbutton 0, active low, asynchronous to CLK; advances the mode.
PB1_n  in  1  pushbutton 1, active low, asynchronous to CLK; clears the mode to OFF.
LED0  out  1  LED 0, active high.
LED1  out  1  LED 1, active high.
MODE  out  2  current mode: 0=OFF, 1=ON, 2=SLOW, 3=FAST.

Behaviour:
- Reset: one clock (CLK); reset RST is asynchronous and active-high. While RST=1, all flops clear:
  - sync stages, debounced levels, debounce counters, edge registers, blink counter and phase are 0;
  - MODE=0, LED0=0, LED1=0.
  - Reset asserted mid-debounce or mid-blink discards all progress.
- Synchroniser: per button, 2-FF chain sampling the inverted pin (~PBx_n), giving an active-high raw level.
- Debounce, per button:
  - a counter runs while the raw level differs from the debounced level;
  - the counter clears to 0 whenever raw equals debounced;
  - when the count reaches DEBOUNCE_CYCLES-1 while still different, the debounced level takes the raw value and the counter clears;
  - a glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Press event: one-cycle pulse on the 0->1 edge of the debounced level. Release produces no event.
- Latency: pin held low from edge 0 -> debounced high after edge 2+DEBOUNCE_CYCLES -> MODE updated after edge 3+DEBOUNCE_CYCLES.
- Mode FSM transitions:
  - PB0 press: OFF->ON->SLOW->FAST->OFF (wraps).
  - PB1 press: any state -> OFF.
  - Both presses in the same cycle: PB1 wins, MODE=OFF.
  - Holding a button produces exactly one event.
- Blink timer:
  - a counter plus a phase bit; the counter counts from 0 to a terminal value T, then returns to 0 and toggles phase;
  - T = BLINK_HALF-1 in SLOW and BLINK_HALF/4-1 in FAST;
  - in OFF and ON, the counter and phase are held at 0;
  - any MODE change clears the counter and phase in the same cycle, so each blink mode starts with phase 0.
- LED outputs (registered, one cycle after MODE/phase):
  - OFF: LED0=0, LED1=0.
  - ON: LED0=1, LED1=1.
  - SLOW/FAST: LED0=phase, LED1=~phase (alternating).

Optional Feature:
PBLED_LONGPRESS_EN
- Defined:
  - a hold counter runs while PB0 is debounced high, saturating at LONG_CYCLES;
  - on the cycle the counter reaches LONG_CYCLES, the FSM goes to OFF;
  - the short-press advance for that press is still applied at press time, and the long-press forcing OFF wins later;
  - the counter clears on release and on reset;
  - a PB1 press in the same cycle gives the same result (OFF).
- Undefined: no hold counter, LONG_CYCLES is unused, PB0 only advances the mode.

Test Plan:
Common bench setup: DEBOUNCE_CYCLES=4, BLINK_HALF=8, LONG_CYCLES=20.
1. RST pulse with both buttons idle (1) -> MODE=0, LED0=LED1=0 immediately, stable for 50 cycles after release.
2. PB0_n low for 3 cycles, then high -> no MODE change. PB0_n low 10 cycles -> MODE=1 exactly 7 cycles after the falling edge, LED0=LED1=1 one cycle later.
3. Four clean PB0 presses -> MODE 1,2,3,0. In SLOW: LED0 toggles every 8 cycles and LED1 is its inverse. In FAST: toggles every 2 cycles. LED0 starts at 0 on mode entry.
4. MODE=2, then PB0 and PB1 pressed on the same cycle -> MODE=0, LEDs 0, blink counter idle.
5. MODE=3, RST asserted mid-blink with a button held -> all outputs 0 asynchronously. After release with the button still held, one press event is generated after 2+4 cycles, giving MODE=1.
6. PBLED_LONGPRESS_EN defined, MODE=0, PB0 held 40 cycles -> MODE=1 at the press, then 0 when the hold count reaches 20. Undefined -> MODE stays 1.
